fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mycpu_pkg.sv | 26 ++
 rtl/pc_next.sv | 28 ++
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types for the CPU front end.
//   pc_sel_t      : PC select encoding driven by the control unit
//   fetch_state_t : instruction fetch FSM states
//   branch_offset : sign-extended 6-bit branch displacement taken from an instruction
package mycpu_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      PS_HOLD = 2'b00,
      PS_INC  = 2'b01,
      PS_BRA  = 2'b10,
      PS_JMP  = 2'b11
   } pc_sel_t;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_WAIT = 1'b1
   } fetch_state_t;

   // Displacement field is split across the instruction: {ir[8:6], ir[2:0]}.
   function automatic logic [15:0] branch_offset(input logic [15:0] ir);
      return {{10{ir[8]}}, ir[8:6], ir[2:0]};
   endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection.
//   pc      : current program counter
//   ps      : PC select (hold / increment / branch / jump)
//   ir      : instruction register, source of the branch displacement
//   ra      : register-file A data, jump target
//   next_pc : candidate PC value; wraps modulo 2^16
module pc_next
   import mycpu_pkg::*;
(
   input  logic [15:0] pc,
   input  pc_sel_t     ps,
   input  logic [15:0] ir,
   input  logic [15:0] ra,
   output logic [15:0] next_pc
);

   always_comb begin
      next_pc = pc;
      unique case (ps)
         PS_HOLD: next_pc = pc;
         PS_INC:  next_pc = pc + 16'd1;
         PS_BRA:  next_pc = pc + branch_offset(ir);
         PS_JMP:  next_pc = ra;
         default: next_pc = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and the instruction register and runs a
// two-state fetch FSM against a request/ack instruction memory.
//   clk, rst_n     : clock, asynchronous active-low reset
//   il_in          : instruction-load request
//   ps_in          : PC select (applied only when idle and not loading)
//   ra_in          : jump target
//   imem_data_in   : memory read data, valid with imem_ack_in
//   imem_ack_in    : memory acknowledge
//   imem_req_out   : registered memory read request
//   imem_addr_out  : registered memory read address
//   ins_out        : instruction register
//   pc_out         : program counter
//   ins_valid_out  : one-cycle pulse when the IR is loaded
//   busy_out       : fetch outstanding
//   err_out        : sticky fetch timeout, cleared only by reset
module fetch_unit
   import mycpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        il_in,
   input  logic [1:0]  ps_in,
   input  logic [15:0] ra_in,
   input  logic [15:0] imem_data_in,
   input  logic        imem_ack_in,
   output logic        imem_req_out,
   output logic [15:0] imem_addr_out,
   output logic [15:0] ins_out,
   output logic [15:0] pc_out,
   output logic        ins_valid_out,
   output logic        busy_out,
   output logic        err_out
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   fetch_state_t     state;
   logic [15:0]      pc_r;
   logic [15:0]      ir_r;
   logic [CNT_W-1:0] wait_cnt;
   logic [15:0]      pc_nxt;

   pc_next u_pc_next (
      .pc      (pc_r),
      .ps      (pc_sel_t'(ps_in)),
      .ir      (ir_r),
      .ra      (ra_in),
      .next_pc (pc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= F_IDLE;
         pc_r          <= RESET_PC;
         ir_r          <= 16'h0000;
         wait_cnt      <= '0;
         imem_req_out  <= 1'b0;
         imem_addr_out <= 16'h0000;
         ins_valid_out <= 1'b0;
         err_out       <= 1'b0;
      end else begin
         ins_valid_out <= 1'b0;
         case (state)
            F_IDLE: begin
               // A load request wins over PC update; ack is ignored here.
               if (il_in) begin
                  imem_req_out  <= 1'b1;
                  imem_addr_out <= pc_r;
                  wait_cnt      <= '0;
                  state         <= F_WAIT;
               end else begin
                  pc_r <= pc_nxt;
               end
            end
            F_WAIT: begin
               // Ack beats timeout when both land in the same cycle.
               if (imem_ack_in) begin
                  ir_r          <= imem_data_in;
                  ins_valid_out <= 1'b1;
                  imem_req_out  <= 1'b0;
                  state         <= F_IDLE;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  err_out      <= 1'b1;
                  imem_req_out <= 1'b0;
                  state        <= F_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= F_IDLE;
         endcase
      end
   end

   assign busy_out = (state == F_WAIT);
   assign pc_out   = pc_r;
   assign ins_out  = ir_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized fetch / PC
// operations. Fetch results go through a scoreboard queue drained by a monitor
// that fires on ins_valid_out; PC, error and handshake state use a plain model.
module tb_fetch_unit;

   localparam int unsigned TIMEOUT = 4;
   localparam logic [15:0] RST_PC  = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        il_in = 1'b0;
   logic [1:0]  ps_in = 2'b00;
   logic [15:0] ra_in = 16'h0000;
   logic [15:0] imem_data_in = 16'h0000;
   logic        imem_ack_in = 1'b0;
   logic        imem_req_out;
   logic [15:0] imem_addr_out;
   logic [15:0] ins_out;
   logic [15:0] pc_out;
   logic        ins_valid_out;
   logic        busy_out;
   logic        err_out;

   fetch_unit #(
      .RESET_PC (RST_PC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .il_in         (il_in),
      .ps_in         (ps_in),
      .ra_in         (ra_in),
      .imem_data_in  (imem_data_in),
      .imem_ack_in   (imem_ack_in),
      .imem_req_out  (imem_req_out),
      .imem_addr_out (imem_addr_out),
      .ins_out       (ins_out),
      .pc_out        (pc_out),
      .ins_valid_out (ins_valid_out),
      .busy_out      (busy_out),
      .err_out       (err_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [15:0] addr;
   } fetch_exp_t;

   fetch_exp_t  exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] pc_m;
   logic [15:0] ir_m;
   logic        err_m;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference PC rule with plain integer arithmetic.
   function automatic logic [15:0] model_next_pc(input logic [15:0] pc, input logic [1:0] ps,
                                                 input logic [15:0] ir, input logic [15:0] ra);
      int bits;
      int off;
      bits = int'({ir[8:6], ir[2:0]});
      off  = (bits >= 32) ? bits - 64 : bits;
      case (ps)
         2'd0:    return pc;
         2'd1:    return 16'((int'(pc) + 1) % 65536);
         2'd2:    return 16'((int'(pc) + off + 65536) % 65536);
         default: return ra;
      endcase
   endfunction

   // Monitor: every IR load must match the oldest outstanding expectation.
   always @(negedge clk) begin
      fetch_exp_t e;
      if (rst_n && ins_valid_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_ins_valid: got pulse expected none (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_ins_out", ins_out, e.data);
            check("sb_fetch_addr", imem_addr_out, e.addr);
         end
      end
   end

   task automatic model_reset();
      pc_m  = RST_PC;
      ir_m  = 16'h0000;
      err_m = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"}, pc_out, RST_PC);
      check({tag, "_ins"}, ins_out, 16'h0000);
      check({tag, "_req"}, imem_req_out, 1'b0);
      check({tag, "_addr"}, imem_addr_out, 16'h0000);
      check({tag, "_valid"}, ins_valid_out, 1'b0);
      check({tag, "_busy"}, busy_out, 1'b0);
      check({tag, "_err"}, err_out, 1'b0);
   endtask

   // One idle cycle with a PC update; stray acks must be ignored.
   task automatic pc_op(input logic [1:0] ps, input logic [15:0] ra);
      il_in        = 1'b0;
      ps_in        = ps;
      ra_in        = ra;
      imem_ack_in  = 1'($urandom_range(0, 1));
      imem_data_in = 16'($urandom);
      pc_m = model_next_pc(pc_m, ps, ir_m, ra);
      @(negedge clk);
      imem_ack_in = 1'b0;
      check("pc_update", pc_out, pc_m);
      check("pc_op_busy", busy_out, 1'b0);
   endtask

   // Fetch with ack in wait cycle d (0 = zero-wait); d > TIMEOUT never acks.
   task automatic fetch(input int d, input logic [15:0] data, input bit noise);
      il_in        = 1'b1;
      ps_in        = 2'($urandom);
      ra_in        = 16'($urandom);
      imem_ack_in  = 1'($urandom_range(0, 1));
      imem_data_in = 16'($urandom);
      @(negedge clk);
      il_in       = 1'b0;
      imem_ack_in = 1'b0;
      for (int i = 0; i <= int'(TIMEOUT); i++) begin
         check("req_held", imem_req_out, 1'b1);
         check("addr_held", imem_addr_out, pc_m);
         check("busy_wait", busy_out, 1'b1);
         check("err_wait", err_out, err_m);
         if (i == d) begin
            imem_ack_in  = 1'b1;
            imem_data_in = data;
            il_in        = 1'b0;
            exp_q.push_back('{data: data, addr: pc_m});
         end else begin
            imem_ack_in  = 1'b0;
            imem_data_in = 16'($urandom);
            if (noise) begin
               il_in = 1'($urandom_range(0, 1));
               ps_in = 2'($urandom);
               ra_in = 16'($urandom);
            end
         end
         @(negedge clk);
         imem_ack_in = 1'b0;
         il_in       = 1'b0;
         if (i == d) break;
      end
      if (d <= int'(TIMEOUT)) begin
         ir_m = data;
         check("ins_valid_pulse", ins_valid_out, 1'b1);
      end else begin
         err_m = 1'b1;
         check("timeout_no_valid", ins_valid_out, 1'b0);
      end
      check("req_dropped", imem_req_out, 1'b0);
      check("busy_dropped", busy_out, 1'b0);
      check("err_flag", err_out, err_m);
      check("ir_value", ins_out, ir_m);
      check("pc_kept", pc_out, pc_m);
      ps_in = 2'b00;
      @(negedge clk);
      check("ins_valid_single", ins_valid_out, 1'b0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      fetch(0, 16'h1234, 1'b0);
      check("first_fetch_ins", ins_out, 16'h1234);

      pc_op(2'b11, 16'h0010);
      pc_op(2'b01, 16'h0000);
      check("inc_const", pc_out, 16'h0011);
      pc_op(2'b11, 16'h0010);
      fetch(0, 16'h01C5, 1'b0);
      pc_op(2'b10, 16'h0000);
      check("branch_back_const", pc_out, 16'h000D);
      pc_op(2'b11, 16'hABCD);
      check("jump_const", pc_out, 16'hABCD);
      pc_op(2'b11, 16'hFFFF);
      pc_op(2'b01, 16'h0000);
      check("wrap_const", pc_out, 16'h0000);
      pc_op(2'b11, 16'h4321);

      fetch(int'(TIMEOUT), 16'h5A5A, 1'b1);
      fetch(int'(TIMEOUT) + 2, 16'h0000, 1'b1);
      check("err_set_const", err_out, 1'b1);
      fetch(1, 16'h0F0F, 1'b0);
      check("err_sticky_const", err_out, 1'b1);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 2) == 0)
            fetch($urandom_range(0, int'(TIMEOUT) + 2), 16'($urandom), 1'b1);
         else
            pc_op(2'($urandom), 16'($urandom));
      end

      // Abort mid-fetch; the late ack after release must be dropped.
      pc_op(2'b11, 16'h2222);
      il_in = 1'b1;
      @(negedge clk);
      il_in = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state("async_reset");
      @(negedge clk);
      rst_n        = 1'b1;
      ps_in        = 2'b00;
      imem_ack_in  = 1'b1;
      imem_data_in = 16'hBEEF;
      @(negedge clk);
      @(negedge clk);
      imem_ack_in = 1'b0;
      check("late_ack_ir", ins_out, 16'h0000);
      check("late_ack_valid", ins_valid_out, 1'b0);
      check("late_ack_pc", pc_out, RST_PC);
      check("late_ack_busy", busy_out, 1'b0);

      fetch(2, 16'hC0DE, 1'b0);
      check("queue_drained", 16'(exp_q.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
